// File: rtl/ksa.sv
// ksa: ARC4 key-scheduling stage. Runs the 256-iteration key schedule over a
// shared single-port 256x8 S memory with synchronous read (data one cycle
// after the address).
// Build option: define KSA_INIT_EN to include the INIT state, which writes
// the identity permutation into S before scheduling. Without it, S must
// already hold the identity (or a previous result) when a run starts.
module ksa (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren
);

    typedef enum logic [2:0] {
        IDLE,
`ifdef KSA_INIT_EN
        INIT,
`endif
        READ_I,
        CALC_J,
        READ_J,
        WRITE_J,
        WRITE_I
    } state_t;

    state_t      state_reg;
    logic [7:0]  i_reg;
    logic [7:0]  j_reg;
    logic [7:0]  si_reg;
    logic [7:0]  sj_reg;
    logic [23:0] key_reg;
    logic [1:0]  kidx_reg;
    logic        rdy_reg;
    logic [7:0]  s_addr_reg;
    logic [7:0]  s_wrdata_reg;
    logic        s_wren_reg;

    logic [7:0]  key_bytes [3];
    logic [7:0]  kb;
    logic [7:0]  j_next;
    logic        last_i;
    logic        accept;

    // Split the latched key into its three bytes, most significant first.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key_bytes
            assign key_bytes[gi] = key_reg[23 - 8*gi -: 8];
        end
    endgenerate

    // Key byte chosen by the mod-3 counter that tracks i.
    always_comb begin
        kb = key_bytes[2];
        case (kidx_reg)
            2'd0:    kb = key_bytes[0];
            2'd1:    kb = key_bytes[1];
            default: kb = key_bytes[2];
        endcase
    end

    // New j uses s[i] arriving this cycle; all sums wrap at 8 bits.
    assign j_next = j_reg + s_rddata + kb;
    assign last_i = (i_reg == 8'hFF);

    // A run is accepted from IDLE, or on the final WRITE_I so that a held
    // en restarts immediately with no idle cycle.
    assign accept = en && ((state_reg == IDLE) ||
                           ((state_reg == WRITE_I) && last_i));

    // s[i] only becomes available during CALC_J, so the address of s[j] is
    // forwarded straight from the adder in that state to keep 5 cycles/i.
    assign s_addr   = (state_reg == CALC_J) ? j_next : s_addr_reg;
    assign s_wrdata = s_wrdata_reg;
    assign s_wren   = s_wren_reg;
    assign rdy      = rdy_reg;

    // Schedule FSM; output registers are loaded for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            i_reg        <= 8'd0;
            j_reg        <= 8'd0;
            si_reg       <= 8'd0;
            sj_reg       <= 8'd0;
            key_reg      <= 24'd0;
            kidx_reg     <= 2'd0;
            rdy_reg      <= 1'b1;
            s_addr_reg   <= 8'd0;
            s_wrdata_reg <= 8'd0;
            s_wren_reg   <= 1'b0;
        end else if (accept) begin
            key_reg      <= key;
            i_reg        <= 8'd0;
            j_reg        <= 8'd0;
            kidx_reg     <= 2'd0;
            rdy_reg      <= 1'b1;
            s_addr_reg   <= 8'd0;
            s_wrdata_reg <= 8'd0;
`ifdef KSA_INIT_EN
            state_reg    <= INIT;
            s_wren_reg   <= 1'b1;
`else
            state_reg    <= READ_I;
            s_wren_reg   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    rdy_reg    <= 1'b1;
                    s_wren_reg <= 1'b0;
                end
`ifdef KSA_INIT_EN
                INIT: begin
                    rdy_reg <= 1'b0;
                    if (last_i) begin
                        state_reg  <= READ_I;
                        i_reg      <= 8'd0;
                        s_addr_reg <= 8'd0;
                        s_wren_reg <= 1'b0;
                    end else begin
                        i_reg        <= i_reg + 8'd1;
                        s_addr_reg   <= i_reg + 8'd1;
                        s_wrdata_reg <= i_reg + 8'd1;
                        s_wren_reg   <= 1'b1;
                    end
                end
`endif
                READ_I: begin
                    rdy_reg   <= 1'b0;
                    state_reg <= CALC_J;
                end
                CALC_J: begin
                    si_reg     <= s_rddata;
                    j_reg      <= j_next;
                    s_addr_reg <= j_next;
                    state_reg  <= READ_J;
                end
                READ_J: begin
                    sj_reg       <= s_rddata;
                    s_addr_reg   <= j_reg;
                    s_wrdata_reg <= si_reg;
                    s_wren_reg   <= 1'b1;
                    state_reg    <= WRITE_J;
                end
                WRITE_J: begin
                    s_addr_reg   <= i_reg;
                    s_wrdata_reg <= sj_reg;
                    s_wren_reg   <= 1'b1;
                    state_reg    <= WRITE_I;
                end
                WRITE_I: begin
                    s_wren_reg <= 1'b0;
                    if (last_i) begin
                        state_reg    <= IDLE;
                        rdy_reg      <= 1'b1;
                        s_addr_reg   <= 8'd0;
                        s_wrdata_reg <= 8'd0;
                    end else begin
                        i_reg      <= i_reg + 8'd1;
                        kidx_reg   <= (kidx_reg == 2'd2) ? 2'd0 : kidx_reg + 2'd1;
                        s_addr_reg <= i_reg + 8'd1;
                        state_reg  <= READ_I;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    rdy_reg    <= 1'b1;
                    s_wren_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ksa.sv
// tb_ksa: directed bench for ksa with a behavioural S memory, a software
// ARC4 key-schedule model and a scoreboard of expected S writes.
module tb_ksa;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  s_addr;
    logic [7:0]  s_rddata;
    logic [7:0]  s_wrdata;
    logic        s_wren;

    always #5 clk = ~clk;

    ksa dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .rdy      (rdy),
        .key      (key),
        .s_addr   (s_addr),
        .s_rddata (s_rddata),
        .s_wrdata (s_wrdata),
        .s_wren   (s_wren)
    );

`ifdef KSA_INIT_EN
    localparam int RUN_CYC  = 1536;
    localparam bit HAS_INIT = 1'b1;
`else
    localparam int RUN_CYC  = 1280;
    localparam bit HAS_INIT = 1'b0;
`endif
    localparam int OFF = HAS_INIT ? 256 : 0;

    // S memory: synchronous read, write on s_wren; load_id forces identity.
    logic [7:0] mem [256];
    logic       load_id = 1'b0;
    always @(posedge clk) begin
        if (load_id) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else begin
            if (s_wren) mem[s_addr] <= s_wrdata;
            s_rddata <= mem[s_addr];
        end
    end

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] obs_log [$];
    logic [7:0]  ref_s [256];
    int          d1, d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference key schedule from the current S (or identity when INIT is
    // built in); pushes every expected {addr,data} write in order.
    task automatic build_ref(input logic [23:0] k);
        logic [7:0] s [256];
        logic [7:0] j, t, kb;
        exp_q.delete();
        obs_log.delete();
        for (int i = 0; i < 256; i++) s[i] = HAS_INIT ? 8'(i) : mem[i];
        if (HAS_INIT) for (int i = 0; i < 256; i++) exp_q.push_back({8'(i), 8'(i)});
        j = 8'd0;
        for (int i = 0; i < 256; i++) begin
            case (i % 3)
                0:       kb = k[23:16];
                1:       kb = k[15:8];
                default: kb = k[7:0];
            endcase
            j = j + s[i] + kb;
            exp_q.push_back({j, s[i]});
            exp_q.push_back({8'(i), s[j]});
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        for (int i = 0; i < 256; i++) ref_s[i] = s[i];
    endtask

    task automatic load_identity();
        @(negedge clk) load_id = 1'b1;
        @(negedge clk) load_id = 1'b0;
    endtask

    task automatic sample_write();
        if (s_wren) begin
            obs_log.push_back({s_addr, s_wrdata});
            if (exp_q.size() == 0) chk("unexpected_write", 32'({s_addr, s_wrdata}), 32'hFFFF_FFFF);
            else chk($sformatf("write#%0d", obs_log.size() - 1), 32'({s_addr, s_wrdata}), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic check_s(input string tag);
        for (int i = 0; i < 256; i++) chk($sformatf("%s_s[%0d]", tag, i), 32'(mem[i]), 32'(ref_s[i]));
    endtask

    // One run: accept (unless already accepted at the current edge), then
    // step cycle by cycle, checking writes, until rdy returns.
    task automatic run_ksa(input logic [23:0] k, input bit hold, input bit pre,
                           input int pulse_cyc, input int rst_cyc, output int done_cyc);
        int cyc;
        if (!pre) begin
            key = k; en = 1'b1;
            @(posedge clk); #1;
        end
        build_ref(k);
        if (!hold) en = 1'b0;
        chk("rdy_after_accept", 32'(rdy), 32'd1);
        sample_write();
        cyc = 0;
        done_cyc = -1;
        while (1) begin
            if (cyc == pulse_cyc) begin en = 1'b1; key = ~k; end
            else if (!hold) begin en = 1'b0; key = k; end
            if (cyc == rst_cyc) rst = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                rst = 1'b0;
                chk("rst_rdy", 32'(rdy), 32'd1);
                chk("rst_wren", 32'(s_wren), 32'd0);
                chk("rst_addr", 32'(s_addr), 32'd0);
                done_cyc = cyc;
                exp_q.delete();
                break;
            end
            if (cyc == 1) chk("rdy_low", 32'(rdy), 32'd0);
            if (cyc >= 2 && rdy) begin
                done_cyc = cyc;
                chk("writes_drained", 32'(exp_q.size()), 32'd0);
                break;
            end
            if (cyc > RUN_CYC + 40) begin
                chk("timeout", 32'(cyc), 32'(RUN_CYC));
                done_cyc = cyc;
                break;
            end
            sample_write();
        end
        $display("run key=%06h done_cyc=%0d writes=%0d", k, done_cyc, obs_log.size());
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; key = 24'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", 32'(rdy), 32'd1);
        chk("reset_wren", 32'(s_wren), 32'd0);
        chk("reset_addr", 32'(s_addr), 32'd0);
        chk("reset_wrdata", 32'(s_wrdata), 32'd0);
        rst = 1'b0;

        // Key 0 on identity: self-swaps at i=0,1, then 3<-2, 2<-3 at i=2.
        load_identity();
        run_ksa(24'h000000, 1'b0, 1'b0, -1, -1, d1);
        chk("k0_done", 32'(d1), 32'(RUN_CYC));
        check_s("k0");
        chk("k0_w0", 32'(obs_log[OFF+0]), 32'h0000);
        chk("k0_w1", 32'(obs_log[OFF+1]), 32'h0000);
        chk("k0_w2", 32'(obs_log[OFF+2]), 32'h0101);
        chk("k0_w3", 32'(obs_log[OFF+3]), 32'h0101);
        chk("k0_w4", 32'(obs_log[OFF+4]), 32'h0302);
        chk("k0_w5", 32'(obs_log[OFF+5]), 32'h0203);

        // Key 0x1E4600, undisturbed.
        load_identity();
        run_ksa(24'h1E4600, 1'b0, 1'b0, -1, -1, d1);
        chk("k1e_done", 32'(d1), 32'(RUN_CYC));
        check_s("k1e");

        // en (with a different key) pulsed mid-run must be ignored.
        load_identity();
        run_ksa(24'h1E4600, 1'b0, 1'b0, 300, -1, d2);
        chk("pulse_done", 32'(d2), 32'(RUN_CYC));
        check_s("pulse");

        // Reset mid-run, then a clean rerun.
        load_identity();
        run_ksa(24'h1E4600, 1'b0, 1'b0, -1, 500, d1);
        chk("rst_cycle", 32'(d1), 32'd501);
        load_identity();
        run_ksa(24'h1E4600, 1'b0, 1'b0, -1, -1, d1);
        chk("rerun_done", 32'(d1), 32'(RUN_CYC));
        check_s("rerun");

        // en held high: second run accepted at the edge rdy rises.
        load_identity();
        run_ksa(24'h000001, 1'b1, 1'b0, -1, -1, d1);
        chk("b2b1_done", 32'(d1), 32'(RUN_CYC));
        check_s("b2b1");
        run_ksa(24'h000001, 1'b0, 1'b1, -1, -1, d2);
        chk("b2b2_done", 32'(d2), 32'(RUN_CYC));
        check_s("b2b2");

        // All-ones key exercises wrap of j+si+kb.
        load_identity();
        run_ksa(24'hFFFFFF, 1'b0, 1'b0, -1, -1, d1);
        chk("kff_done", 32'(d1), 32'(RUN_CYC));
        check_s("kff");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
